// File: rtl/camera_stream_gen_if.sv
// Parallel camera bus (OV7670 style) plus the generator's control and status.
// The generator takes the master modport and the consumer or test harness takes the slave modport.
interface camera_stream_gen_if;
    logic        enable_in;
    logic [1:0]  pattern_sel;
    logic [15:0] color_in;
    logic        pclk_out;
    logic        vsync_out;
    logic        href_out;
    logic [7:0]  pixel_out;
    logic [7:0]  frame_count_out;
    logic        busy_out;

    modport master (
        input  enable_in, pattern_sel, color_in,
        output pclk_out, vsync_out, href_out, pixel_out, frame_count_out, busy_out
    );

    modport slave (
        output enable_in, pattern_sel, color_in,
        input  pclk_out, vsync_out, href_out, pixel_out, frame_count_out, busy_out
    );
endinterface

// File: rtl/camera_stream_gen.sv
// Synthetic OV7670-style RGB565 stream source with colour bar, solid, gradient and moving box patterns.
// Each pixel is sent as two bytes, high byte first. All stream outputs change on the falling edge of pclk.
module camera_stream_gen #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int H_BLANK     = 144,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10,
    parameter int CLK_DIV     = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    camera_stream_gen_if.master   bus
);
    localparam int LINE_TICKS   = 2 * H_ACTIVE + H_BLANK;
    localparam int VSYNC_TICKS  = VSYNC_LINES * LINE_TICKS;
    localparam int VBACK_TICKS  = V_BACK * LINE_TICKS;
    localparam int VFRONT_TICKS = V_FRONT * LINE_TICKS;
    localparam int ACTIVE_TICKS = 2 * H_ACTIVE;
    localparam int BAR_W        = H_ACTIVE / 8;
    localparam int BOX_SIZE     = 64;
    localparam int BOX_TOP      = V_ACTIVE / 2 - BOX_SIZE / 2;
    localparam int DIV_W        = $clog2(CLK_DIV);

    typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, HBLANK, VFRONT} state_t;

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick_end;
    state_t           state_q, state_d;
    logic [31:0]      tick_q, tick_d;
    logic [15:0]      y_q, y_d;
    logic [7:0]       fc_d;
    logic [1:0]       pat_q;
    logic [15:0]      color_q;
    logic             latch;
    logic             last;
    int               phase_len;
    logic [15:0]      px_x;
    logic [2:0]       bar_idx;
    int               box_left;
    logic             in_box;
    logic [15:0]      pix_val;
    logic [7:0]       byte_d;

    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return 16'hFFFF;
            3'd1:    return 16'hFFE0;
            3'd2:    return 16'h07FF;
            3'd3:    return 16'h07E0;
            3'd4:    return 16'hF81F;
            3'd5:    return 16'hF800;
            3'd6:    return 16'h001F;
            default: return 16'h0000;
        endcase
    endfunction

    // A tick ends on the last clk_in cycle of the divider, which is also where pclk falls.
    assign tick_end = (div_q == DIV_W'(CLK_DIV - 1));
    assign div_d    = tick_end ? '0 : div_q + DIV_W'(1);

    always_comb begin
        case (state_q)
            VSYNC:   phase_len = VSYNC_TICKS;
            VBACK:   phase_len = VBACK_TICKS;
            ACTIVE:  phase_len = ACTIVE_TICKS;
            HBLANK:  phase_len = H_BLANK;
            VFRONT:  phase_len = VFRONT_TICKS;
            default: phase_len = 1;
        endcase
    end

    assign last = (tick_q == 32'(phase_len - 1));

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
        state_d = state_q;
        tick_d  = tick_q;
        y_d     = y_q;
        fc_d    = bus.frame_count_out;
        latch   = 1'b0;
        if (state_q == IDLE) begin
            if (bus.enable_in) begin
                state_d = VSYNC;
                tick_d  = '0;
                latch   = 1'b1;
            end
        end else if (!last) begin
            tick_d = tick_q + 32'd1;
        end else begin
            tick_d = '0;
            case (state_q)
                VSYNC: state_d = VBACK;
                VBACK: begin
                    state_d = ACTIVE;
                    y_d     = '0;
                end
                ACTIVE: state_d = HBLANK;
                HBLANK: begin
                    if (int'(y_q) < V_ACTIVE - 1) begin
                        state_d = ACTIVE;
                        y_d     = y_q + 16'd1;
                    end else begin
                        state_d = VFRONT;
                    end
                end
                VFRONT: begin
                    fc_d = bus.frame_count_out + 8'd1;
                    if (bus.enable_in) begin
                        state_d = VSYNC;
                        latch   = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // The pixel for the next tick is computed during the current tick from the next counters.
    // The value is registered on the edge where that tick begins.
    always_comb begin
        px_x     = tick_d[16:1];
        bar_idx  = 3'(px_x / 16'(BAR_W));
        box_left = (int'(bus.frame_count_out) * 4) % H_ACTIVE;
        in_box   = (int'(px_x) >= box_left) && (int'(px_x) < box_left + BOX_SIZE) &&
                   (int'(y_d) >= BOX_TOP) && (int'(y_d) < BOX_TOP + BOX_SIZE);
        pix_val  = '0;
        unique case (pat_q)
            2'd0: pix_val = bar_color(bar_idx);
            2'd1: pix_val = color_q;
            2'd2: pix_val = {px_x[9:5], y_d[8:3], bus.frame_count_out[4:0]};
            2'd3: pix_val = in_box ? color_q : 16'h0000;
        endcase
        byte_d = (state_d == ACTIVE) ? (tick_d[0] ? pix_val[7:0] : pix_val[15:8]) : 8'h00;
    end

    // NOTE: all state registers use non-blocking assignments, so every register here samples the values from before the edge.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            div_q               <= '0;
            state_q             <= IDLE;
            tick_q              <= '0;
            y_q                 <= '0;
            pat_q               <= '0;
            color_q             <= '0;
            bus.pclk_out        <= 1'b0;
            bus.vsync_out       <= 1'b0;
            bus.href_out        <= 1'b0;
            bus.pixel_out       <= '0;
            bus.frame_count_out <= '0;
            bus.busy_out        <= 1'b0;
        end else begin
            div_q        <= div_d;
            bus.pclk_out <= (div_d >= DIV_W'(CLK_DIV / 2));
            if (tick_end) begin
                state_q             <= state_d;
                tick_q              <= tick_d;
                y_q                 <= y_d;
                bus.frame_count_out <= fc_d;
                bus.vsync_out       <= (state_d == VSYNC);
                bus.href_out        <= (state_d == ACTIVE);
                bus.pixel_out       <= byte_d;
                bus.busy_out        <= (state_d != IDLE);
                if (latch) begin
                    pat_q   <= bus.pattern_sel;
                    color_q <= bus.color_in;
                end
            end
        end
    end
endmodule

// File: tb/tb_camera_stream_gen.sv
// Self-checking bench for camera_stream_gen. A per-tick frame model checks the small configuration.
// A second, tiny instance runs enough frames to wrap the frame counter.
module tb_camera_stream_gen;
    localparam int H   = 16;
    localparam int V   = 4;
    localparam int HB  = 4;
    localparam int VSL = 1;
    localparam int VB  = 1;
    localparam int VF  = 1;
    localparam int CD  = 2;
    localparam int LT          = 2 * H + HB;
    localparam int FRAME_TICKS = (VSL + VB + V + VF) * LT;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    logic rst_w  = 1'b0;
    always #5 clk_in = ~clk_in;

    camera_stream_gen_if bus ();
    camera_stream_gen_if wbus ();

    camera_stream_gen #(.H_ACTIVE(H), .V_ACTIVE(V), .H_BLANK(HB), .VSYNC_LINES(VSL),
                        .V_BACK(VB), .V_FRONT(VF), .CLK_DIV(CD))
        dut (.clk_in(clk_in), .rst_in(rst_in), .bus(bus));

    camera_stream_gen #(.H_ACTIVE(8), .V_ACTIVE(1), .H_BLANK(1), .VSYNC_LINES(1),
                        .V_BACK(1), .V_FRONT(1), .CLK_DIV(2))
        wrap_dut (.clk_in(clk_in), .rst_in(rst_w), .bus(wbus));

    int n_checks = 0;
    int n_errors = 0;
    bit mon_en   = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_pixel(input int pat, input logic [15:0] col,
                                              input int x, input int y, input int fc);
        logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                  16'hF81F, 16'hF800, 16'h001F, 16'h0000};
        int left;
        case (pat)
            0: return bars[x * 8 / H];
            1: return col;
            2: return 16'(((x >> 5) & 31) << 11 | ((y >> 3) & 63) << 5 | (fc & 31));
            default: begin
                left = (fc * 4) % H;
                if (x >= left && x < left + 64 && y >= V / 2 - 32 && y < V / 2 + 32) return col;
                return 16'h0000;
            end
        endcase
    endfunction

    // Expected {busy, vsync, href, byte} for tick t of a frame (t=0 is the first vsync tick).
    function automatic logic [10:0] ref_tick(input int t, input int pat, input logic [15:0] col,
                                             input int fc);
        int act0 = (VSL + VB) * LT;
        int line, pos;
        logic [15:0] pix;
        if (t < VSL * LT) return {1'b1, 1'b1, 1'b0, 8'h00};
        if (t < act0 || t >= act0 + V * LT) return {1'b1, 1'b0, 1'b0, 8'h00};
        line = (t - act0) / LT;
        pos  = (t - act0) % LT;
        if (pos >= 2 * H) return {1'b1, 1'b0, 1'b0, 8'h00};
        pix = ref_pixel(pat, col, pos / 2, line, fc);
        return {1'b1, 1'b0, 1'b1, (pos % 2 == 1) ? pix[7:0] : pix[15:8]};
    endfunction

    // Returns at the negedge of clk_in in the high half of the next pclk tick.
    task automatic next_tick();
        bit seen_low  = 1'b0;
        bit seen_high = 1'b0;
        for (int i = 0; i < 4 * CD && !seen_high; i++) begin
            @(negedge clk_in);
            if (!bus.pclk_out) seen_low = 1'b1;
            else if (seen_low) seen_high = 1'b1;
        end
        check("pclk_tick", 32'(seen_high), 32'd1);
    endtask

    task automatic sync_frame();
        for (int i = 0; i < 600 && !bus.vsync_out; i++) next_tick();
        check("sync_vsync", 32'(bus.vsync_out), 32'd1);
    endtask

    // Checks one full frame. The current sample is tick 0. At tick apply_t the inputs for later frames are driven.
    task automatic check_frame(input int pat, input logic [15:0] col, input int fc, input int apply_t,
                               input int a_pat, input logic [15:0] a_col, input logic a_en);
        logic [10:0] obs;
        check("frame_count", 32'(bus.frame_count_out), 32'(fc & 255));
        for (int t = 0; t < FRAME_TICKS; t++) begin
            if (t > 0) next_tick();
            if (t == apply_t) begin
                bus.pattern_sel = 2'(a_pat);
                bus.color_in    = a_col;
                bus.enable_in   = a_en;
            end
            obs = {bus.busy_out, bus.vsync_out, bus.href_out, bus.pixel_out};
            check($sformatf("frame_p%0d_t%0d", pat, t), 32'(obs), 32'(ref_tick(t, pat, col, fc)));
        end
    endtask

    // Stream outputs may only change on the clk_in edge where pclk falls.
    logic [9:0] mon_prev;
    logic       pclk_mon_prev;
    always @(posedge clk_in) begin
        #1;
        if (mon_en && ({bus.vsync_out, bus.href_out, bus.pixel_out} != mon_prev))
            check("edge_align", 32'({pclk_mon_prev, bus.pclk_out}), 32'b10);
        mon_prev      = {bus.vsync_out, bus.href_out, bus.pixel_out};
        pclk_mon_prev = bus.pclk_out;
    end

    initial begin
        logic [15:0] col_a, col_b, col_c, col_d;
        int          pat_r, last_fc, changes, wraps;

        bus.enable_in    = 1'b0;
        bus.pattern_sel  = 2'd0;
        bus.color_in     = 16'h0000;
        wbus.enable_in   = 1'b1;
        wbus.pattern_sel = 2'd0;
        wbus.color_in    = 16'h1234;
        col_a = 16'($urandom);
        col_b = 16'($urandom);
        col_c = 16'($urandom);
        col_d = 16'($urandom);

        repeat (3) @(negedge clk_in);
        check("rst_pclk", 32'(bus.pclk_out), 32'd0);
        check("rst_sync", 32'({bus.vsync_out, bus.href_out, bus.busy_out}), 32'd0);
        check("rst_pixel", 32'(bus.pixel_out), 32'd0);
        check("rst_fcount", 32'(bus.frame_count_out), 32'd0);
        rst_in = 1'b1;
        rst_w  = 1'b1;

        for (int i = 0; i < 5; i++) begin
            next_tick();
            check("idle_quiet", 32'({bus.busy_out, bus.vsync_out, bus.href_out, bus.pixel_out}), 32'd0);
        end
        mon_en = 1'b1;

        bus.enable_in = 1'b1;
        sync_frame();
        check_frame(0, 16'h0000, 0, 100, 1, 16'hA5C3, 1'b1);
        next_tick();
        check_frame(1, 16'hA5C3, 1, 100, 0, col_a, 1'b1);
        next_tick();
        check_frame(0, 16'h0000, 2, 100, 2, col_a, 1'b1);
        next_tick();
        check_frame(2, col_a, 3, 100, 3, col_b, 1'b1);
        next_tick();
        check_frame(3, col_b, 4, 100, 3, col_c, 1'b1);
        next_tick();
        check_frame(3, col_c, 5, 120, 1, col_d, 1'b0);

        for (int i = 0; i < 50; i++) begin
            next_tick();
            check("drop_idle", 32'({bus.busy_out, bus.vsync_out, bus.href_out}), 32'd0);
        end

        pat_r           = int'($urandom_range(0, 3));
        bus.pattern_sel = 2'(pat_r);
        bus.color_in    = col_d;
        bus.enable_in   = 1'b1;
        sync_frame();
        for (int i = 0; i < 82; i++) next_tick();
        mon_en = 1'b0;
        #2;
        rst_in = 1'b0;
        #1;
        check("async_rst_outs", 32'({bus.pclk_out, bus.vsync_out, bus.href_out, bus.busy_out}), 32'd0);
        check("async_rst_data", 32'({bus.pixel_out, bus.frame_count_out}), 32'd0);
        @(negedge clk_in);
        rst_in = 1'b1;
        repeat (2) @(negedge clk_in);
        mon_en = 1'b1;
        sync_frame();
        check_frame(pat_r, col_d, 0, -1, pat_r, col_d, 1'b1);

        last_fc = int'(wbus.frame_count_out);
        changes = 0;
        wraps   = 0;
        for (int c = 0; c < 40000 && changes < 256; c++) begin
            @(negedge clk_in);
            if (int'(wbus.frame_count_out) != last_fc) begin
                check("wrap_step", 32'(wbus.frame_count_out), 32'((last_fc + 1) & 255));
                if (last_fc == 255) wraps++;
                last_fc = int'(wbus.frame_count_out);
                changes++;
            end
        end
        check("wrap_changes", 32'(changes), 32'd256);
        check("wrap_seen", 32'(wraps), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/camera_stream_gen.md
Name: camera_stream_gen

Overview:
Transmit-side counterpart of the camera pixel-bus receiver. Generates an OV7670-style parallel stream: pclk, vsync, href, and 8-bit RGB565 data with two bytes per pixel, high byte first. The stream carries synthetic test patterns. It drives camera_read and the vision pipeline in simulation, and on hardware through a switch-selected mux in front of the camera input buffers, so lane/jump detection can be exercised without a sensor.

Parameters:
H_ACTIVE, 640, pixels per active line (even, ≥8, multiple of 8)
V_ACTIVE, 480, active lines per frame
H_BLANK, 144, pclk ticks with href low after each active line
VSYNC_LINES, 3, line-times vsync held high
V_BACK, 17, blank line-times after vsync
V_FRONT, 10, blank line-times after last active line
CLK_DIV, 2, clk_in cycles per pclk tick (even, ≥2)

Ports:
clk_in  input  1  system clock
rst_in  input  1  asynchronous, active-low reset
enable_in  input  1  stream enable; sampled only at frame boundaries
pattern_sel  input  2  0 colour bars, 1 solid, 2 gradient, 3 moving box
color_in  input  16  RGB565 value for solid pattern and box colour
pclk_out  output  1  pixel clock
vsync_out  output  1  frame sync, active high
href_out  output  1  line valid, active high
pixel_out  output  8  data byte
frame_count_out  output  8  completed frames, wraps at 255
busy_out  output  1  high whenever not in IDLE

Behaviour:
- Reset (rst_in low, async): state IDLE; all outputs 0; all counters 0. Released synchronously on the next clk_in edge.
- Tick: CLK_DIV clk_in cycles.
  - pclk_out is low for the first CLK_DIV/2 cycles and high for the rest.
  - vsync_out, href_out and pixel_out change only on the first cycle of a tick, i.e. on the pclk falling edge. They are stable across the rising edge.
  - All outputs are registered.
- LINE_TICKS = 2*H_ACTIVE + H_BLANK.
- FSM states: IDLE → VSYNC → VBACK → ACTIVE ↔ HBLANK → VFRONT → (VSYNC | IDLE).
  - IDLE: pclk_out is still toggling; other outputs 0. Moves to VSYNC at a tick start when enable_in = 1.
  - VSYNC: vsync_out = 1 for VSYNC_LINES*LINE_TICKS ticks. On entry, latch pattern_sel and color_in. Mid-frame changes to either have no effect.
  - VBACK: V_BACK*LINE_TICKS ticks; vsync_out and href_out both 0.
  - ACTIVE: href_out = 1 for 2*H_ACTIVE ticks. Even tick carries pixel[15:8]; odd tick carries pixel[7:0]. x counts 0..H_ACTIVE-1; y is the line index.
  - HBLANK: H_BLANK ticks, href_out = 0, pixel_out = 0. Then go to ACTIVE if y < V_ACTIVE-1 (y increments), otherwise go to VFRONT.
  - VFRONT: V_FRONT*LINE_TICKS ticks. At its end, frame_count_out increments (mod 256). Then go to VSYNC if enable_in = 1, else IDLE.
  - enable_in deasserting mid-frame does not truncate the frame.
- Patterns (RGB565):
  - 0, colour bars: bar = x / (H_ACTIVE/8). Bar values in order: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - 1, solid: latched color_in.
  - 2, gradient: {x[9:5], y[8:3], frame_count_out[4:0]}. Truncate x and y to these bits.
  - 3, moving box:
    - Latched color_in inside a 64×64 box whose left edge = (frame_count_out*4) mod H_ACTIVE and top = V_ACTIVE/2-32; 0000 elsewhere.
    - The box clips at the right edge; it does not wrap.
- Pixel value is computed one tick before its high byte is output. No bubble is allowed between the two bytes.
- Reset asserted mid-frame returns immediately to IDLE with outputs 0. A new frame after reset always begins with VSYNC.

Test Plan:
- Bench parameters for all scenarios: H_ACTIVE=16, V_ACTIVE=4, H_BLANK=4, VSYNC_LINES=1, V_BACK=1, V_FRONT=1, CLK_DIV=2.
1. enable_in=1 after reset, pattern 0 → vsync high 36 ticks, then 36 low, then 4 lines of 32 href-high ticks plus 4 low. Byte pairs: FF,FF ×2, FF,E0 ×2, 07,FF ×2, …, 00,00 ×2.
2. pattern 1, color_in=A5C3 → every active byte pair is A5,C3. pattern_sel changed to 0 mid-frame → no effect until the next VSYNC.
3. Loopback into camera_read → 64 pixel_valid pulses per frame, pixel_data matching the generated values, frame_done once per frame, frame_count_out = 1 after the first frame.
4. enable_in dropped during ACTIVE line 1 → frame completes through VFRONT, then IDLE with busy_out=0. vsync_out does not rise again.
5. rst_in pulsed low mid-line → all outputs 0 asynchronously. After release with enable_in=1, the next output is a full-length vsync pulse.
6. Check at every tick: data/href/vsync transitions only at pclk falling edges. frame_count_out wraps 255→0 when forced through 256 frames.
